// File: rtl/bf_pkg.sv
// Shared constants, types and FSM encoding for the bilateral-filter window fetch path.
package bf_pkg;
  localparam int IMG_W = 256;
  localparam int IMG_H = 256;
  localparam int K     = 5;
  localparam int DW    = 8;
  localparam int AW    = 16;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = AW - CW;
  localparam int HALF  = (K - 1) / 2;

  typedef logic [DW-1:0] pixel_t;
  typedef logic [AW-1:0] addr_t;
  typedef logic [CW-1:0] col_t;
  typedef logic [RW-1:0] row_t;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} fsm_t;

  localparam addr_t LAST_ADDR  = addr_t'(IMG_W * IMG_H - 1);
  localparam addr_t CENTRE_OFF = addr_t'(HALF * IMG_W + HALF);
  localparam row_t  ROW_MIN    = row_t'(K - 1);
  localparam col_t  COL_MIN    = col_t'(K - 1);
endpackage

// File: rtl/bf_window_fetch_line_buffer.sv
// One image line of pixels; registered read, write port shares the column index space.
module bf_line_buffer
  import bf_pkg::*;
(
  input  logic   clk,
  input  logic   wr_en,
  input  col_t   wr_col,
  input  pixel_t wr_data,
  input  col_t   rd_col,
  output pixel_t rd_data
);
  pixel_t mem [IMG_W];
  pixel_t rd_data_q;

  // The caller reads one column ahead, so the old contents at a column are
  // already on rd_data when that column is overwritten.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_col] <= wr_data;
    rd_data_q <= mem[rd_col];
  end

  assign rd_data = rd_data_q;
endmodule

// File: rtl/bf_window_fetch.sv
// Raster-order image fetch with K-1 line buffers, emitting every interior KxK window
// and its centre address over a valid/ready stream.
module bf_window_fetch
  import bf_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output addr_t             in_addr,
  input  pixel_t            in_data,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [K*K*DW-1:0] win_data,
  output addr_t             win_addr,
  output logic              busy,
  output logic              done
);
  fsm_t state_q, state_d;
  addr_t p_q, p_d, cnt_q, cnt_d, win_addr_q, win_addr_d;
  logic rd_q, rd_d, skid_valid_q, skid_valid_d;
  pixel_t skid_q, skid_d;
  logic [K*K*DW-1:0] arr_q, arr_d, arr_shift, win_data_q, win_data_d;
  logic win_valid_q, win_valid_d, win_last_q, win_last_d;

  logic adv, issue, cap, emit, start_acc;
  pixel_t cap_pix;
  col_t cap_col, rd_col;
  row_t cap_row;
  pixel_t lb_rd [K-1];
  pixel_t lb_wr [K-1];
  pixel_t col_new [K];

  assign adv       = !win_valid_q || win_ready;
  assign start_acc = (state_q == IDLE) && start;
  assign issue     = (state_q == FETCH) && adv;
  assign cap       = adv && (skid_valid_q || rd_q);
  assign cap_pix   = skid_valid_q ? skid_q : in_data;
  assign cap_col   = cnt_q[CW-1:0];
  assign cap_row   = cnt_q[AW-1:CW];
  // Windows whose right edge is in the first K-1 columns would straddle two rows.
  assign emit      = cap && (cap_row >= ROW_MIN) && (cap_col >= COL_MIN);
  assign rd_col    = cap ? cap_col + col_t'(1) : cap_col;

  genvar gi;
  generate
    for (gi = 0; gi < K - 1; gi++) begin : g_lb
      if (gi == 0) begin : g_head
        assign lb_wr[gi] = cap_pix;
      end else begin : g_chain
        assign lb_wr[gi] = lb_rd[gi-1];
      end
      bf_line_buffer u_lb (
        .clk     (clk),
        .wr_en   (cap),
        .wr_col  (cap_col),
        .wr_data (lb_wr[gi]),
        .rd_col  (rd_col),
        .rd_data (lb_rd[gi])
      );
      assign col_new[K-2-gi] = lb_rd[gi];
    end
  endgenerate
  assign col_new[K-1] = cap_pix;

  always_comb begin
    arr_shift = arr_q;
    for (int r = 0; r < K; r++) begin
      for (int c = 0; c < K - 1; c++) begin
        arr_shift[(r*K+c)*DW +: DW] = arr_q[(r*K+c+1)*DW +: DW];
      end
      arr_shift[(r*K+K-1)*DW +: DW] = col_new[r];
    end
  end

  always_comb begin
    p_d          = p_q;
    rd_d         = issue;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    cnt_d        = cnt_q;
    arr_d        = cap ? arr_shift : arr_q;
    if (issue) p_d = p_q + addr_t'(1);
    // A stall never coincides with a full skid, so one entry is enough.
    if (rd_q && !adv) begin
      skid_valid_d = 1'b1;
      skid_d       = in_data;
    end else if (cap && skid_valid_q) begin
      skid_valid_d = 1'b0;
    end
    if (cap) cnt_d = cnt_q + addr_t'(1);
    if (start_acc) begin
      p_d          = '0;
      rd_d         = 1'b0;
      skid_valid_d = 1'b0;
      cnt_d        = '0;
    end
  end

  always_comb begin
    win_valid_d = win_valid_q;
    win_data_d  = win_data_q;
    win_addr_d  = win_addr_q;
    win_last_d  = win_last_q;
    if (adv) begin
      win_valid_d = emit;
      if (emit) begin
        win_data_d = arr_shift;
        win_addr_d = cnt_q - CENTRE_OFF;
        win_last_d = (cnt_q == LAST_ADDR);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q          <= '0;
      rd_q         <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      cnt_q        <= '0;
      arr_q        <= '0;
      win_valid_q  <= 1'b0;
      win_data_q   <= '0;
      win_addr_q   <= '0;
      win_last_q   <= 1'b0;
    end else begin
      p_q          <= p_d;
      rd_q         <= rd_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      cnt_q        <= cnt_d;
      arr_q        <= arr_d;
      win_valid_q  <= win_valid_d;
      win_data_q   <= win_data_d;
      win_addr_q   <= win_addr_d;
      win_last_q   <= win_last_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FETCH;
      FETCH:   if (issue && (p_q == LAST_ADDR)) state_d = DRAIN;
      DRAIN:   if (win_valid_q && win_ready && win_last_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == FETCH) || (state_q == DRAIN);
    done = (state_q == DONE);
  end

  assign in_addr   = p_q;
  assign win_valid = win_valid_q;
  assign win_data  = win_data_q;
  assign win_addr  = win_addr_q;
endmodule

// File: tb/tb_bf_window_fetch.sv
// Bench for bf_window_fetch: ramp image source, window-order model and directed stall/reset/start cases.
module tb_bf_window_fetch;
  import bf_pkg::*;

  localparam int NW   = IMG_W - K + 1;
  localparam int NH   = IMG_H - K + 1;
  localparam int NWIN = NW * NH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic win_ready = 1'b1;
  addr_t in_addr, addr_prev, win_addr;
  pixel_t in_data;
  logic win_valid, busy, done;
  logic [K*K*DW-1:0] win_data;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  bf_window_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .win_data  (win_data),
    .win_addr  (win_addr),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic pixel_t pix_a(int a);
    logic [15:0] u;
    u = 16'(a);
    return pixel_t'(u[7:0] + u[15:8]);
  endfunction

  // Source image with one cycle of read latency.
  always @(posedge clk) addr_prev <= in_addr;
  assign in_data = pix_a(int'(addr_prev));

  function automatic int exp_addr(int idx);
    return (idx / NW + (K - 1) / 2) * IMG_W + idx % NW + (K - 1) / 2;
  endfunction

  function automatic logic [K*K*DW-1:0] exp_win(int idx);
    logic [K*K*DW-1:0] w;
    int top, left;
    top  = idx / NW;
    left = idx % NW;
    w = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        w[(r*K+c)*DW +: DW] = pix_a((top + r) * IMG_W + left + c);
    return w;
  endfunction

  task automatic check(string name, logic [255:0] act, logic [255:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic timeout(string name);
    total++;
    bad++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Compare process: every handshake against the model, plus ordering/holding rules.
  int exp_idx = 0, start_cyc = 0, last_hs_cyc = 0, prev_acc = -1;
  logic seen_first = 1'b0, stall_prev = 1'b0, done_prev = 1'b0;
  addr_t last_addr = '0, hold_addr = '0, nxt;
  logic [K*K*DW-1:0] hold_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_idx = 0; seen_first = 0; stall_prev = 0; done_prev = 0; prev_acc = -1;
      last_addr = in_addr;
    end else begin
      if (start && !busy && !done) begin
        exp_idx = 0; seen_first = 0; stall_prev = 0; prev_acc = -1;
        start_cyc = cyc + 1;
      end
      if (in_addr !== last_addr) begin
        nxt = last_addr + addr_t'(1);
        check("addr_order", in_addr, nxt);
        last_addr = in_addr;
      end
      if (win_valid) begin
        if (!seen_first) begin
          seen_first = 1;
          check("first_valid_cycle", cyc - start_cyc, 1030);
        end
        if (stall_prev) begin
          check("hold_addr", win_addr, hold_addr);
          check("hold_data", win_data, hold_data);
        end
        if (win_ready) begin
          check("win_addr", win_addr, exp_addr(exp_idx));
          check("win_data", win_data, exp_win(exp_idx));
          if (exp_idx == 0) begin
            check("first_addr", win_addr, 514);
            check("first_px00", win_data[7:0], 0);
            check("first_px22", win_data[103:96], 4);
            check("first_px44", win_data[199:192], 8);
          end
          if (exp_idx == NWIN - 1) check("last_addr", win_addr, 65021);
          if (prev_acc == 1021) check("after_row_end", win_addr, 1026);
          prev_acc = int'(win_addr);
          last_hs_cyc = cyc;
          exp_idx++;
        end
        stall_prev = !win_ready;
        hold_addr = win_addr;
        hold_data = win_data;
      end else begin
        stall_prev = 0;
      end
      if (done) begin
        check("done_timing", cyc - last_hs_cyc, 1);
        check("win_count", exp_idx, NWIN);
        check("done_pulse", done_prev, 0);
      end
      done_prev = done;
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  initial begin
    int stall_left;
    logic found, did_long, did_short, done_seen;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_addr", in_addr, 0);
    check("rst_win_valid", win_valid, 0);
    check("rst_win_data", win_data, 0);
    check("rst_win_addr", win_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("idle_busy", busy, 0);

    // Frame interrupted by reset at p=3000.
    pulse_start();
    check("f0_busy", busy, 1);
    found = 0;
    for (int i = 0; i < 5000 && !found; i++) begin
      @(posedge clk); #1;
      if (in_addr == 3000) found = 1;
    end
    if (!found) timeout("wait_p3000");
    rst_n = 1'b0;
    #1;
    check("midrst_in_addr", in_addr, 0);
    check("midrst_win_valid", win_valid, 0);
    check("midrst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", win_valid, 0);
    check("post_rst_in_addr", in_addr, 0);

    // Full frame, ready high except a 100-cycle stall at the row-end window and a 1-cycle stall.
    pulse_start();
    check("f1_busy", busy, 1);
    check("f1_in_addr", in_addr, 0);
    stall_left = 0; did_long = 0; did_short = 0; done_seen = 0;
    for (int i = 0; i < 70000 && !done_seen; i++) begin
      @(posedge clk); #1;
      start = (i == 5000);
      if (done) begin
        done_seen = 1;
        start = 1'b1;
      end else begin
        if (stall_left == 0 && win_valid && win_addr == 1021 && !did_long) begin
          stall_left = 100; did_long = 1;
        end
        if (stall_left == 0 && win_valid && win_addr == 2000 && !did_short) begin
          stall_left = 1; did_short = 1;
        end
        win_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end
    end
    if (!done_seen) timeout("wait_done");
    @(posedge clk); #1;
    start = 1'b0;
    win_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("done_start_ignored", busy, 0);
    check("after_done_valid", win_valid, 0);

    // Second frame with random back-pressure, cut short by reset.
    pulse_start();
    check("f2_busy", busy, 1);
    check("f2_in_addr", in_addr, 0);
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      win_ready = 1'($urandom_range(0, 1));
    end
    check("f2_progress", exp_idx > 1000, 1);
    rst_n = 1'b0;
    win_ready = 1'b1;
    #1;
    check("end_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
